dpi_stream_sched: RTL and testbench

DPI_STREAM_SCHED -- requirements
Module: dpi_stream_sched

---
 rtl/dpi_stream_sched_if.sv | 27 ++
 rtl/dpi_stream_sched.sv | 186 ++++++++++++++++++
 tb/tb_dpi_stream_sched.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dpi_stream_sched_if.sv
// rtl/dpi_stream_sched_if.sv - upstream byte-stream handshake bundle for dpi_stream_sched
//
// Signals:
//   in_valid      source -> sched  byte beat valid
//   in_ready      sched  -> source beat accepted when in_valid && in_ready
//   in_data[7:0]  source -> sched  packet byte
//   in_sop        source -> sched  first beat of packet
//   in_eop        source -> sched  last beat of packet (sop&eop = 1-byte packet)
//   in_stream_id  source -> sched  stream id, meaningful on the sop beat
interface dpi_stream_sched_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_sop;
    logic       in_eop;
    logic [5:0] in_stream_id;

    modport master (
        output in_valid, in_data, in_sop, in_eop, in_stream_id,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_data, in_sop, in_eop, in_stream_id,
        output in_ready
    );
endinterface

// File: rtl/dpi_stream_sched.sv
// rtl/dpi_stream_sched.sv - per-packet scheduler feeding a bank of regex matcher wrappers
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   up (slave)            upstream byte stream (valid/ready/data/sop/eop/stream_id)
//   cfg_we/cfg_stream_id/cfg_enable_mask  enable-table write port
//   cfg_clear             clear the seen-stream bitmap
//   char_in/char_in_vld   registered byte stream to the matchers
//   load_state            one-cycle pulse starting matcher state restore
//   stream_id/new_stream_id/enable  per-packet context, latched at sop
//   eop                   one-cycle pulse finalizing the packet
//   busy                  scheduler not idle
//   pkt_count             eop pulses issued (wrapping)
//   err_count             protocol-error beats (saturating)
module dpi_stream_sched #(
    parameter int N_REGEX   = 8,
    parameter int LOAD_GAP  = 2,
    parameter int DRAIN_GAP = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    dpi_stream_sched_if.slave   up,
    input  logic                cfg_we,
    input  logic [5:0]          cfg_stream_id,
    input  logic [N_REGEX-1:0]  cfg_enable_mask,
    input  logic                cfg_clear,
    output logic [7:0]          char_in,
    output logic                char_in_vld,
    output logic                load_state,
    output logic [5:0]          stream_id,
    output logic                new_stream_id,
    output logic                eop,
    output logic [N_REGEX-1:0]  enable,
    output logic                busy,
    output logic [15:0]         pkt_count,
    output logic [15:0]         err_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_GAP,
        S_STREAM,
        S_DRAIN,
        S_EOP
    } state_t;

    state_t             state;
    logic               ready_q;
    logic               first_beat;
    logic [15:0]        cnt;
    logic [63:0]        seen;
    logic [N_REGEX-1:0] en_table [64];

    logic sop_wait;
    logic accept;
    logic in_window;
    logic err_evt;

    // A sop beat is held off in IDLE so the matchers can restore state first;
    // it is accepted later as the first data byte of the packet.
    assign sop_wait    = up.in_valid & up.in_sop;
    assign up.in_ready = (state == S_IDLE) ? (ready_q & ~sop_wait) : ready_q;
    assign accept      = up.in_valid & up.in_ready;
    assign in_window   = (state == S_LOAD) || (state == S_GAP) || (state == S_STREAM);

    // Anything accepted in IDLE is a stray non-sop beat; inside a packet a
    // sop on any beat other than the first is a protocol error.
    assign err_evt = accept & ((state == S_IDLE) | (up.in_sop & ~first_beat));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            ready_q       <= 1'b0;
            first_beat    <= 1'b0;
            cnt           <= '0;
            char_in       <= '0;
            char_in_vld   <= 1'b0;
            load_state    <= 1'b0;
            stream_id     <= '0;
            new_stream_id <= 1'b0;
            eop           <= 1'b0;
            enable        <= '0;
            busy          <= 1'b0;
            pkt_count     <= '0;
            err_count     <= '0;
        end else begin
            char_in_vld <= 1'b0;
            load_state  <= 1'b0;
            eop         <= 1'b0;

            if (err_evt && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end

            if (accept && in_window) begin
                char_in     <= up.in_data;
                char_in_vld <= 1'b1;
                first_beat  <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    ready_q <= 1'b1;
                    if (sop_wait) begin
                        state         <= S_LOAD;
                        load_state    <= 1'b1;
                        busy          <= 1'b1;
                        stream_id     <= up.in_stream_id;
                        enable        <= en_table[up.in_stream_id];
                        new_stream_id <= ~seen[up.in_stream_id];
                        first_beat    <= 1'b1;
                        // cnt = cycles left until STREAM, counting the LOAD cycle.
                        cnt           <= 16'(LOAD_GAP);
                        // in_ready opens one cycle before STREAM so the first
                        // byte reaches char_in exactly LOAD_GAP after load_state.
                        ready_q       <= (LOAD_GAP == 1);
                    end
                end

                S_LOAD, S_GAP, S_STREAM: begin
                    if (accept && up.in_eop) begin
                        state   <= S_DRAIN;
                        ready_q <= 1'b0;
                        cnt     <= 16'(DRAIN_GAP - 1);
                    end else if (state != S_STREAM) begin
                        if (cnt <= 16'd1) begin
                            state <= S_STREAM;
                        end else begin
                            state   <= S_GAP;
                            cnt     <= cnt - 16'd1;
                            ready_q <= (cnt <= 16'd2);
                        end
                    end
                end

                S_DRAIN: begin
                    // Entered the cycle of the final char_in_vld; eop lands
                    // DRAIN_GAP cycles after it.
                    if (cnt == 16'd0) begin
                        state <= S_EOP;
                        eop   <= 1'b1;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end

                S_EOP: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    ready_q   <= 1'b1;
                    pkt_count <= pkt_count + 16'd1;
                end

                default: begin
                    state   <= S_IDLE;
                    busy    <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Enable table and seen bitmap. The per-packet enable is copied at sop,
    // so table writes never disturb a packet already in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seen <= '0;
            for (int i = 0; i < 64; i++) begin
                en_table[i] <= '0;
            end
        end else begin
            if (cfg_we) begin
                en_table[cfg_stream_id] <= cfg_enable_mask;
            end
            if (cfg_clear) begin
                seen <= '0;
            end
            // Later assignment wins: a coincident clear cannot drop this set.
            if (state == S_EOP) begin
                seen[stream_id] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dpi_stream_sched.sv
// tb/tb_dpi_stream_sched.sv - self-checking bench for dpi_stream_sched
module tb_dpi_stream_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        cfg_we;
    logic        cfg_clear;
    logic [5:0]  cfg_stream_id;
    logic [7:0]  cfg_enable_mask;
    logic [7:0]  char_in;
    logic        char_in_vld;
    logic        load_state;
    logic [5:0]  stream_id;
    logic        new_stream_id;
    logic        eop;
    logic [7:0]  enable;
    logic        busy;
    logic [15:0] pkt_count;
    logic [15:0] err_count;

    dpi_stream_sched_if ifc ();

    dpi_stream_sched dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .up              (ifc),
        .cfg_we          (cfg_we),
        .cfg_stream_id   (cfg_stream_id),
        .cfg_enable_mask (cfg_enable_mask),
        .cfg_clear       (cfg_clear),
        .char_in         (char_in),
        .char_in_vld     (char_in_vld),
        .load_state      (load_state),
        .stream_id       (stream_id),
        .new_stream_id   (new_stream_id),
        .eop             (eop),
        .enable          (enable),
        .busy            (busy),
        .pkt_count       (pkt_count),
        .err_count       (err_count)
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t sb [$];
    bit   sb_en = 1'b1;

    int         ld_cyc    = 0;
    int         first_vld = -1;
    int         last_vld  = 0;
    int         eop_cyc   = 0;
    int         n_vld     = 0;
    int         n_eop     = 0;
    logic [5:0] ld_id     = '0;
    logic [7:0] ld_en     = '0;
    logic       ld_new    = 1'b0;
    exp_t       cur;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: packet context at load_state, scoreboard pop on char_in_vld,
    // drain timing and context hold at eop.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (load_state) begin
                ld_cyc    = cyc;
                ld_id     = stream_id;
                ld_en     = enable;
                ld_new    = new_stream_id;
                first_vld = -1;
                n_vld     = 0;
            end
            if (char_in_vld && sb_en) begin
                check("vld_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    cur = sb.pop_front();
                    check("char_in", 32'(char_in), 32'(cur.data));
                    check("vld_cycle", cyc, cur.cyc);
                end
            end
            if (char_in_vld) begin
                if (first_vld < 0) first_vld = cyc;
                last_vld = cyc;
                n_vld++;
            end
            if (eop) begin
                eop_cyc = cyc;
                n_eop++;
                check("eop_after_last_vld", cyc - last_vld, 32'd3);
                check("hold_stream_id", 32'(stream_id), 32'(ld_id));
                check("hold_enable", 32'(enable), 32'(ld_en));
                check("hold_new_id", 32'(new_stream_id), 32'(ld_new));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input bit push);
        int t    = 0;
        bit done = 1'b0;
        while (!done && t < 60) begin
            @(negedge clk);
            if (ifc.in_ready === 1'b1) begin
                if (push) sb.push_back(exp_t'{data: ifc.in_data, cyc: cyc + 1});
                done = 1'b1;
            end
            t++;
        end
        check("beat_accepted", 32'(done), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input logic [5:0] id, input int n, input int gap, input int mid_sop);
        for (int i = 0; i < n; i++) begin
            ifc.in_valid     = 1'b1;
            ifc.in_data      = 8'($urandom_range(0, 255));
            ifc.in_sop       = (i == 0) || (i == mid_sop);
            ifc.in_eop       = (i == n - 1);
            ifc.in_stream_id = id;
            drive_beat(1'b1);
            ifc.in_valid = 1'b0;
            ifc.in_sop   = 1'b0;
            ifc.in_eop   = 1'b0;
            if (gap > 0 && i < n - 1) tick(gap);
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (busy !== 1'b0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("idle_reached", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, 32'({ifc.in_ready, char_in_vld, load_state, eop, busy, new_stream_id}), 32'd0);
        check({tag, "_data"}, 32'({stream_id, enable, char_in}), 32'd0);
        check({tag, "_cnt"}, {pkt_count, err_count}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    int eops_before;

    initial begin
        rst_n            = 1'b0;
        cfg_we           = 1'b0;
        cfg_clear        = 1'b0;
        cfg_stream_id    = '0;
        cfg_enable_mask  = '0;
        ifc.in_valid     = 1'b0;
        ifc.in_data      = '0;
        ifc.in_sop       = 1'b0;
        ifc.in_eop       = 1'b0;
        ifc.in_stream_id = '0;
        tick(3);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(2);

        // First packet on id 5 with mask 0x81.
        cfg_we = 1'b1; cfg_stream_id = 6'd5; cfg_enable_mask = 8'h81;
        tick(1);
        cfg_we = 1'b0;
        send_pkt(6'd5, 4, 0, -1);
        wait_idle();
        check("p1_new", 32'(ld_new), 32'd1);
        check("p1_en", 32'(ld_en), 32'h81);
        check("p1_id", 32'(ld_id), 32'd5);
        check("p1_first_vld", first_vld - ld_cyc, 32'd2);
        check("p1_eop", eop_cyc - ld_cyc, 32'd8);
        check("p1_nvld", n_vld, 32'd4);
        check("p1_pkt_count", 32'(pkt_count), 32'd1);

        // Seen bitmap and its clear.
        send_pkt(6'd5, 3, 0, -1);
        wait_idle();
        check("p2_new", 32'(ld_new), 32'd0);
        cfg_clear = 1'b1;
        tick(1);
        cfg_clear = 1'b0;
        send_pkt(6'd5, 2, 0, -1);
        wait_idle();
        check("p3_new", 32'(ld_new), 32'd1);
        check("p3_en", 32'(ld_en), 32'h81);

        // 1-byte packet, then a 5-byte packet with 3-cycle valid gaps.
        send_pkt(6'd9, 1, 0, -1);
        wait_idle();
        check("one_byte_nvld", n_vld, 32'd1);
        check("one_byte_first_vld", first_vld - ld_cyc, 32'd2);
        send_pkt(6'd9, 5, 3, -1);
        wait_idle();
        check("gap_nvld", n_vld, 32'd5);
        check("gap_span", last_vld - first_vld, 32'd16);

        // Protocol errors: stray non-sop beat in IDLE, then a mid-packet sop.
        check("err_before", 32'(err_count), 32'd0);
        ifc.in_valid = 1'b1; ifc.in_sop = 1'b0; ifc.in_eop = 1'b0; ifc.in_data = 8'h55;
        drive_beat(1'b0);
        ifc.in_valid = 1'b0;
        check("err_idle", 32'(err_count), 32'd1);
        send_pkt(6'd3, 4, 0, 2);
        wait_idle();
        check("err_mid_sop", 32'(err_count), 32'd2);
        check("mid_sop_nvld", n_vld, 32'd4);

        // Table write during a packet leaves the in-flight enable alone.
        cfg_we = 1'b1; cfg_stream_id = 6'd7; cfg_enable_mask = 8'h3C;
        tick(1);
        cfg_we = 1'b0;
        fork
            send_pkt(6'd7, 6, 0, -1);
            begin
                tick(5);
                cfg_we = 1'b1; cfg_stream_id = 6'd7; cfg_enable_mask = 8'h00;
                tick(1);
                cfg_we = 1'b0;
            end
        join
        wait_idle();
        check("p7a_en", 32'(ld_en), 32'h3C);
        send_pkt(6'd7, 2, 0, -1);
        wait_idle();
        check("p7b_en", 32'(ld_en), 32'h00);
        check("pkt_count_8", 32'(pkt_count), 32'd8);

        // Reset mid-STREAM on id 5 (already seen).
        eops_before      = n_eop;
        sb_en            = 1'b0;
        ifc.in_valid     = 1'b1;
        ifc.in_sop       = 1'b1;
        ifc.in_eop       = 1'b0;
        ifc.in_data      = 8'h11;
        ifc.in_stream_id = 6'd5;
        tick(3);
        ifc.in_sop = 1'b0;
        tick(2);
        check("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick(1);
        @(negedge clk);
        check_all_zero("mid_reset");
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        rst_n = 1'b1;
        tick(10);
        check("no_eop_on_abort", n_eop, eops_before);
        sb_en = 1'b1;
        send_pkt(6'd5, 3, 0, -1);
        wait_idle();
        check("post_reset_new", 32'(ld_new), 32'd1);
        check("post_reset_pkt_count", 32'(pkt_count), 32'd1);
        check("sb_drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
